// File: rtl/writeback_arbiter_if.sv
// Bundle of the four execution-pipe result ports, the flush strobe and the writeback bus.
// The arbiter uses the slave modport; the result producers / wake-up consumers use master.
interface writeback_arbiter_if;
    logic        snoop_hit;

    logic        alu_valid;
    logic        alu_ready;
    logic [3:0]  alu_dst_rob;
    logic [31:0] alu_value;

    logic        mul_valid;
    logic        mul_ready;
    logic [3:0]  mul_dst_rob;
    logic [31:0] mul_value;

    logic        mem_valid;
    logic        mem_ready;
    logic [3:0]  mem_dst_rob;
    logic [31:0] mem_value;
    logic        mem_lsmiss;

    logic        bru_valid;
    logic        bru_ready;
    logic [3:0]  bru_dst_rob;
    logic [31:0] bru_value;

    logic        wb_en;
    logic [3:0]  wb_dst_rob;
    logic [31:0] wb_value;
    logic        wb_lsmiss;
    logic [1:0]  wb_src;

    modport slave (
        input  snoop_hit,
        input  alu_valid, alu_dst_rob, alu_value,
        input  mul_valid, mul_dst_rob, mul_value,
        input  mem_valid, mem_dst_rob, mem_value, mem_lsmiss,
        input  bru_valid, bru_dst_rob, bru_value,
        output alu_ready, mul_ready, mem_ready, bru_ready,
        output wb_en, wb_dst_rob, wb_value, wb_lsmiss, wb_src
    );

    modport master (
        output snoop_hit,
        output alu_valid, alu_dst_rob, alu_value,
        output mul_valid, mul_dst_rob, mul_value,
        output mem_valid, mem_dst_rob, mem_value, mem_lsmiss,
        output bru_valid, bru_dst_rob, bru_value,
        input  alu_ready, mul_ready, mem_ready, bru_ready,
        input  wb_en, wb_dst_rob, wb_value, wb_lsmiss, wb_src
    );
endinterface

// File: rtl/writeback_arbiter.sv
// Per-pipe result FIFOs (ALU/MUL/MEM/BRU) round-robin merged onto one registered writeback bus.
// Optional macro WRITEBACK_ARBITER_BYPASS_EN: when every FIFO is empty, an input skips its FIFO.
module writeback_arbiter #(
    parameter int FIFO_DEPTH = 2
) (
    input logic                clk,
    input logic                resetn,
    writeback_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int ENT_W = 37;

    logic [3:0]       in_valid;
    logic [ENT_W-1:0] in_ent [4];
    logic [3:0]       ready;
    logic [3:0]       not_empty;
    logic [ENT_W-1:0] head [4];
    logic [3:0]       push_en;
    logic [3:0]       pop_en;

    // Entry layout is {dst_rob, value, lsmiss}; only MEM can report a miss.
    assign in_valid  = {bus.bru_valid, bus.mem_valid, bus.mul_valid, bus.alu_valid};
    assign in_ent[0] = {bus.alu_dst_rob, bus.alu_value, 1'b0};
    assign in_ent[1] = {bus.mul_dst_rob, bus.mul_value, 1'b0};
    assign in_ent[2] = {bus.mem_dst_rob, bus.mem_value, bus.mem_lsmiss};
    assign in_ent[3] = {bus.bru_dst_rob, bus.bru_value, 1'b0};

    assign bus.alu_ready = ready[0];
    assign bus.mul_ready = ready[1];
    assign bus.mem_ready = ready[2];
    assign bus.bru_ready = ready[3];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_fifo
            logic [ENT_W-1:0] mem_q [FIFO_DEPTH];
            logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
            logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
            logic [CNT_W-1:0] count_q, count_d;

            assign ready[gi]     = (count_q != CNT_W'(FIFO_DEPTH));
            assign not_empty[gi] = (count_q != '0);
            assign head[gi]      = mem_q[rd_ptr_q];

            always_comb begin
                wr_ptr_d = wr_ptr_q;
                rd_ptr_d = rd_ptr_q;
                count_d  = count_q;
                if (bus.snoop_hit) begin
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    count_d  = '0;
                end else begin
                    if (push_en[gi]) wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    if (pop_en[gi])  rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    count_d = count_q + CNT_W'(push_en[gi]) - CNT_W'(pop_en[gi]);
                end
            end

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    count_q  <= '0;
                end else begin
                    wr_ptr_q <= wr_ptr_d;
                    rd_ptr_q <= rd_ptr_d;
                    count_q  <= count_d;
                end
            end

            always_ff @(posedge clk) begin
                if (push_en[gi]) mem_q[wr_ptr_q] <= in_ent[gi];
            end
        end
    endgenerate

    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic             wb_en_q, wb_en_d;
    logic [3:0]       wb_dst_rob_q, wb_dst_rob_d;
    logic [31:0]      wb_value_q, wb_value_d;
    logic             wb_lsmiss_q, wb_lsmiss_d;
    logic [1:0]       wb_src_q, wb_src_d;

    logic             byp_sel;
    logic [3:0]       cand;
    logic             grant_vld;
    logic [1:0]       grant_idx;
    logic [1:0]       scan_idx;
    logic             commit;
    logic [ENT_W-1:0] grant_ent;

    always_comb begin
`ifdef WRITEBACK_ARBITER_BYPASS_EN
        byp_sel = (not_empty == 4'b0);
`else
        byp_sel = 1'b0;
`endif
        // While bypassing, the live inputs compete instead of the FIFO heads.
        cand      = byp_sel ? in_valid : not_empty;
        grant_vld = 1'b0;
        grant_idx = rr_ptr_q;
        scan_idx  = rr_ptr_q;
        for (int k = 0; k < 4; k++) begin
            scan_idx = rr_ptr_q + 2'(k);
            if (!grant_vld && cand[scan_idx]) begin
                grant_vld = 1'b1;
                grant_idx = scan_idx;
            end
        end

        commit = grant_vld & ~bus.snoop_hit;
        pop_en = 4'b0;
        if (commit && !byp_sel) pop_en[grant_idx] = 1'b1;
        push_en = in_valid & ready & {4{~bus.snoop_hit}};
        if (commit && byp_sel) push_en[grant_idx] = 1'b0;
        grant_ent = byp_sel ? in_ent[grant_idx] : head[grant_idx];
    end

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        wb_en_d      = 1'b0;
        wb_dst_rob_d = wb_dst_rob_q;
        wb_value_d   = wb_value_q;
        wb_lsmiss_d  = wb_lsmiss_q;
        wb_src_d     = wb_src_q;
        if (bus.snoop_hit) begin
            rr_ptr_d = 2'd0;
        end else if (grant_vld) begin
            rr_ptr_d     = grant_idx + 2'd1;
            wb_en_d      = 1'b1;
            wb_dst_rob_d = grant_ent[36:33];
            wb_value_d   = grant_ent[32:1];
            wb_lsmiss_d  = grant_ent[0];
            wb_src_d     = grant_idx;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr_q     <= 2'd0;
            wb_en_q      <= 1'b0;
            wb_dst_rob_q <= 4'd0;
            wb_value_q   <= 32'd0;
            wb_lsmiss_q  <= 1'b0;
            wb_src_q     <= 2'd0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            wb_en_q      <= wb_en_d;
            wb_dst_rob_q <= wb_dst_rob_d;
            wb_value_q   <= wb_value_d;
            wb_lsmiss_q  <= wb_lsmiss_d;
            wb_src_q     <= wb_src_d;
        end
    end

    assign bus.wb_en      = wb_en_q;
    assign bus.wb_dst_rob = wb_dst_rob_q;
    assign bus.wb_value   = wb_value_q;
    assign bus.wb_lsmiss  = wb_lsmiss_q;
    assign bus.wb_src     = wb_src_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios plus random traffic,
// all compared cycle by cycle against a queue-based reference model.
module tb_writeback_arbiter;
    localparam int DEPTH = 2;
`ifdef WRITEBACK_ARBITER_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef logic [36:0] ent_t;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic [3:0]  tv;
    logic [3:0]  trob [4];
    logic [31:0] tval [4];
    logic        tls;
    logic        tsnoop;

    writeback_arbiter_if bus ();

    assign bus.snoop_hit   = tsnoop;
    assign bus.alu_valid   = tv[0];
    assign bus.alu_dst_rob = trob[0];
    assign bus.alu_value   = tval[0];
    assign bus.mul_valid   = tv[1];
    assign bus.mul_dst_rob = trob[1];
    assign bus.mul_value   = tval[1];
    assign bus.mem_valid   = tv[2];
    assign bus.mem_dst_rob = trob[2];
    assign bus.mem_value   = tval[2];
    assign bus.mem_lsmiss  = tls;
    assign bus.bru_valid   = tv[3];
    assign bus.bru_dst_rob = trob[3];
    assign bus.bru_value   = tval[3];

    writeback_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state: one queue per pipe, scan pointer and expected bus.
    ent_t        mq [4][$];
    int          rr;
    logic        e_en;
    logic [3:0]  e_dst;
    logic [31:0] e_val;
    logic        e_ls;
    logic [1:0]  e_src;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic ent_t mk_ent(input int i);
        return {trob[i], tval[i], (i == 2) ? tls : 1'b0};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mq[i].delete();
        rr = 0; e_en = 0; e_dst = 0; e_val = 0; e_ls = 0; e_src = 0;
    endtask

    task automatic idle();
        tv = 4'b0; tsnoop = 1'b0; tls = 1'b0;
    endtask

    task automatic check_bus();
        chk("wb_en",      bus.wb_en,      e_en);
        chk("wb_dst_rob", bus.wb_dst_rob, e_dst);
        chk("wb_value",   bus.wb_value,   e_val);
        chk("wb_lsmiss",  bus.wb_lsmiss,  e_ls);
        chk("wb_src",     bus.wb_src,     e_src);
    endtask

    // Advance one clock: predict from the rules, clock the DUT, compare.
    task automatic step();
        logic [3:0] rdy;
        bit         hs [4];
        bit         all_empty;
        bit         byp;
        int         g;
        int         j;
        ent_t       e;
        rdy = {bus.bru_ready, bus.mem_ready, bus.mul_ready, bus.alu_ready};
        all_empty = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ready%0d", i), rdy[i], mq[i].size() != DEPTH);
            hs[i] = tv[i] && (mq[i].size() < DEPTH);
            if (mq[i].size() != 0) all_empty = 1'b0;
        end
        if (tsnoop) begin
            for (int i = 0; i < 4; i++) mq[i].delete();
            rr = 0;
            e_en = 0;
        end else begin
            g = -1; byp = 0; e = '0;
            if (BYP && all_empty) begin
                for (int k = 0; k < 4; k++) begin
                    j = (rr + k) % 4;
                    if (g < 0 && tv[j]) g = j;
                end
                byp = (g >= 0);
                if (byp) e = mk_ent(g);
            end else begin
                for (int k = 0; k < 4; k++) begin
                    j = (rr + k) % 4;
                    if (g < 0 && mq[j].size() != 0) g = j;
                end
                if (g >= 0) e = mq[g].pop_front();
            end
            for (int i = 0; i < 4; i++)
                if (hs[i] && !(byp && i == g)) mq[i].push_back(mk_ent(i));
            if (g >= 0) begin
                e_en = 1; e_dst = e[36:33]; e_val = e[32:1]; e_ls = e[0];
                e_src = 2'(g); rr = (g + 1) % 4;
            end else begin
                e_en = 0;
            end
        end
        @(posedge clk);
        #1;
        check_bus();
    endtask

    task automatic push1(input int p, input logic [3:0] rob, input logic [31:0] val);
        tv[p] = 1'b1; trob[p] = rob; tval[p] = val;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin trob[i] = '0; tval[i] = '0; end
        idle();
        model_reset();
        resetn = 1'b0;
        #12;
        check_bus();
        chk("rst_ready", {bus.bru_ready, bus.mem_ready, bus.mul_ready, bus.alu_ready}, 4'hf);
        @(negedge clk);
        resetn = 1'b1;

        // ALU single push, latency check against fixed values
        push1(0, 4'd3, 32'h1234);
        step();
        idle();
`ifdef WRITEBACK_ARBITER_BYPASS_EN
        chk("t1_en", bus.wb_en, 1'b1);
        chk("t1_rob", bus.wb_dst_rob, 4'd3);
        chk("t1_val", bus.wb_value, 32'h1234);
        chk("t1_src", bus.wb_src, 2'd0);
        step();
        chk("t1_en_off", bus.wb_en, 1'b0);
`else
        chk("t1_en_early", bus.wb_en, 1'b0);
        step();
        chk("t1_en", bus.wb_en, 1'b1);
        chk("t1_rob", bus.wb_dst_rob, 4'd3);
        chk("t1_val", bus.wb_value, 32'h1234);
        chk("t1_src", bus.wb_src, 2'd0);
        step();
        chk("t1_en_off", bus.wb_en, 1'b0);
`endif

        // Flush to return the scan pointer to ALU, then all four pipes at once
        tsnoop = 1'b1; step(); idle();
        for (int p = 0; p < 4; p++) push1(p, 4'(p + 1), 32'hA000 + 32'(p));
        step(); idle();
        for (int c = 0; c < 5; c++) step();

        // MEM miss flag in and out
        push1(2, 4'd7, 32'hBEEF); tls = 1'b1; step(); idle();
        for (int c = 0; c < 3; c++) step();
        push1(2, 4'd8, 32'hCAFE); tls = 1'b0; step(); idle();
        for (int c = 0; c < 3; c++) step();

        // ALU and MUL streaming together
        for (int c = 0; c < 12; c++) begin
            push1(0, 4'(c), 32'h100 + 32'(c));
            push1(1, 4'(c + 3), 32'h200 + 32'(c));
            step();
        end
        idle();
        for (int c = 0; c < 5; c++) step();

        // Fill MUL to two entries, then flush with an ALU push in the same cycle
        for (int p = 0; p < 4; p++) push1(p, 4'(p + 9), 32'hD00 + 32'(p));
        step(); idle();
        push1(1, 4'd14, 32'hD10); step(); idle();
        push1(0, 4'd15, 32'hD20); tsnoop = 1'b1; step(); idle();
        for (int c = 0; c < 4; c++) step();

        // Asynchronous reset in the middle of a burst
        for (int p = 0; p < 4; p++) push1(p, 4'(p + 5), 32'hE00 + 32'(p));
        step();
        step();
        idle();
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_en", bus.wb_en, 1'b0);
        chk("async_rst_ready", {bus.bru_ready, bus.mem_ready, bus.mul_ready, bus.alu_ready}, 4'hf);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        for (int c = 0; c < 3; c++) step();

        // Random traffic with occasional flushes
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < 4; p++) begin
                tv[p]   = ($urandom_range(0, 99) < 45);
                trob[p] = 4'($urandom);
                tval[p] = $urandom;
            end
            tls    = 1'($urandom);
            tsnoop = ($urandom_range(0, 39) == 0);
            step();
        end
        idle();
        for (int c = 0; c < 6; c++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Producer side of the issue stage's writeback wake-up interface (wb_en / wb_dst_rob / wb_value / wb_lsmiss).
- Collects completed results from the four execution pipes (ALU, MUL, MEM, BRU), buffers each pipe in a small FIFO, and round-robin arbitrates one result per cycle onto a registered writeback bus.
- The bus feeds issue-queue wake-up and ROB writeback.

Parameters:
- FIFO_DEPTH, 2, entries per pipe FIFO; power of two, at least 2.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- snoop_hit  in  1  pipeline flush; discards all buffered and in-flight results
- alu_valid  in  1  ALU result valid
- alu_ready  out  1  ALU FIFO can accept
- alu_dst_rob  in  4  ALU destination ROB index
- alu_value  in  32  ALU result
- mul_valid / mul_ready / mul_dst_rob / mul_value  in/out/in/in  1/1/4/32  MUL result port, same semantics as ALU
- mem_valid / mem_ready / mem_dst_rob / mem_value  in/out/in/in  1/1/4/32  MEM result port, same semantics as ALU
- mem_lsmiss  in  1  load/store missed; result is not a valid wake-up
- bru_valid / bru_ready / bru_dst_rob / bru_value  in/out/in/in  1/1/4/32  BRU result port, same semantics as ALU
- wb_en  out  1  writeback valid
- wb_dst_rob  out  4  writeback ROB index
- wb_value  out  32  writeback value
- wb_lsmiss  out  1  writeback is a load/store miss
- wb_src  out  2  granted pipe: 0 ALU, 1 MUL, 2 MEM, 3 BRU (debug and verification)

Behaviour:
- Single clock domain. resetn is asynchronous and active-low.
- Reset values:
  - All FIFO counts and read/write pointers = 0.
  - rr_ptr = 0.
  - wb_en = 0, wb_dst_rob = 0, wb_value = 0, wb_lsmiss = 0, wb_src = 0.
  - All *_ready = 1 once reset deasserts (FIFOs empty).
- Input handshake:
  - A push occurs when x_valid & x_ready at a rising edge.
  - x_ready = (count_x != FIFO_DEPTH). It is registered-count based; a same-cycle pop does not raise ready.
- FIFO entry fields: {dst_rob, value, lsmiss}. lsmiss is tied to 0 for ALU, MUL and BRU.
- FIFOs use circular pointers that wrap modulo FIFO_DEPTH.
- A simultaneous push and pop on the same FIFO leaves the count unchanged.
- Arbitration (combinational each cycle):
  - Scan pipes rr_ptr, rr_ptr+1, rr_ptr+2, rr_ptr+3 (mod 4).
  - Grant the first pipe with a non-empty FIFO, and pop that FIFO.
  - On a grant, rr_ptr <= grant+1 (mod 4). With no grant, rr_ptr holds.
- Output register:
  - On a grant: wb_en <= 1; wb_dst_rob, wb_value, wb_lsmiss, wb_src <= the popped entry and grant index.
  - With no grant: wb_en <= 0 and the data fields hold their previous values.
  - Outputs are pure flop outputs.
- Latency: a result pushed at edge T appears on the wb bus after edge T+1, i.e. 2 cycles minimum.
- Throughput: 1 result per cycle total. A single pipe can sustain 1 per cycle when FIFO_DEPTH >= 2.
- Flush: at an edge where snoop_hit = 1:
  - All FIFO counts and pointers clear.
  - Any pushes handshaken in that cycle are dropped.
  - No pop is committed and wb_en <= 0.
  - rr_ptr <= 0.
- Reset mid-operation: asynchronous clear to the reset values, regardless of pending pushes.
- Ordering: results within one pipe leave in FIFO order. There is no ordering guarantee across pipes.

Optional Feature:
- Macro: WRITEBACK_ARBITER_BYPASS_EN
- Defined: in a cycle where all FIFOs are empty and snoop_hit = 0, a handshaking input goes straight to the output register without entering its FIFO, giving 1-cycle latency.
  - The bypass input is the first valid pipe in the rr_ptr scan order.
  - That pipe counts as granted and rr_ptr updates.
  - Other inputs handshaking in the same cycle are pushed into their FIFOs normally.
- Undefined: no bypass; every result passes through its FIFO with 2-cycle minimum latency.

Test Plan:
- Reset, then ALU push {rob 3, 0x1234}: wb_en = 1, wb_dst_rob = 3, wb_value = 0x1234, wb_src = 0 two cycles later (one cycle with BYPASS_EN); wb_en = 0 the next cycle.
- All four pipes push in one cycle (robs 1, 2, 3, 4): wb outputs robs 1, 2, 3, 4 on four consecutive cycles, wb_src 0, 1, 2, 3; rr_ptr ends at 0.
- MEM push {rob 7, lsmiss = 1}: wb_lsmiss = 1, wb_src = 2; next MEM push with lsmiss = 0 gives wb_lsmiss = 0.
- Hold ALU pushes every cycle while MUL pushes continuously, FIFO_DEPTH = 2: grants alternate 0, 1, 0, 1; alu_ready drops when count = 2, no result is lost, and per-pipe order is preserved.
- Fill MUL FIFO with 2 entries, assert snoop_hit with an ALU push in the same cycle: next cycle wb_en = 0, all readies = 1, and none of the three results ever appear.
- Assert resetn = 0 asynchronously mid-burst: wb_en falls immediately without a clock edge; after release all FIFOs are empty.
